// File: rtl/regfile_sb.sv
// Purpose : register file (x0 hardwired to 0) with a per-register busy scoreboard for RAW hazards.
// Latency : reads and stall are combinational (0 cycles); writes, busy bits and pending_cnt update at posedge clk.
// Backpr. : no flow control; stall tells the issue stage that a read source is still pending.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   ad1, ad2             read indices -> ALUop1, regOp2 (combinational)
//   ad3, WE3, WD3        write-back port; a write-back also clears the busy bit
//   issue_en, issue_rd   issued instruction that will later write issue_rd (sets busy)
//   a0                   contents of register DBG_ADDR
//   stall                a read source is busy and not being forwarded this cycle
//   pending_cnt          registered population count of busy bits
//
// Optional feature: define REGFILE_BYPASS_EN to forward WD3 to a read port whose
// index matches a same-cycle write-back; that source then does not stall.
module regfile_sb #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DBG_ADDR      = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] ad1,
  input  logic [ADDRESS_WIDTH-1:0] ad2,
  input  logic [ADDRESS_WIDTH-1:0] ad3,
  input  logic                     WE3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  input  logic                     issue_en,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  output logic [DATA_WIDTH-1:0]    ALUop1,
  output logic [DATA_WIDTH-1:0]    regOp2,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic                     stall,
  output logic [ADDRESS_WIDTH:0]   pending_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX = DBG_ADDR[ADDRESS_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;

  logic wb_vld;
  logic iss_vld;
  logic cnt_inc;
  logic cnt_dec;
  logic bypass1;
  logic bypass2;

  // Index 0 is excluded from both write-back and issue, so regs[0] and busy[0]
  // never leave their reset value of 0.
  assign wb_vld  = WE3 && (ad3 != '0);
  assign iss_vld = issue_en && (issue_rd != '0);

  // Count only real transitions of a busy bit. Issue wins over a same-register
  // write-back, so that write-back never decrements.
  assign cnt_inc = iss_vld && !busy[issue_rd];
  assign cnt_dec = wb_vld && busy[ad3] && !(iss_vld && (issue_rd == ad3));

`ifdef REGFILE_BYPASS_EN
  assign bypass1 = wb_vld && (ad3 == ad1);
  assign bypass2 = wb_vld && (ad3 == ad2);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  // Data array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_vld) begin
      regs[ad3] <= WD3;
    end
  end

  // Scoreboard: clear on write-back first, then set on issue so issue wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wb_vld) begin
        busy[ad3] <= 1'b0;
      end
      if (iss_vld) begin
        busy[issue_rd] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_cnt <= '0;
    end else begin
      pending_cnt <= pending_cnt
                   + {{ADDRESS_WIDTH{1'b0}}, cnt_inc}
                   - {{ADDRESS_WIDTH{1'b0}}, cnt_dec};
    end
  end

  assign ALUop1 = bypass1 ? WD3 : regs[ad1];
  assign regOp2 = bypass2 ? WD3 : regs[ad2];
  assign a0     = regs[DBG_IDX];
  assign stall  = (busy[ad1] && !bypass1) || (busy[ad2] && !bypass2);

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ad1, ad2, ad3, issue_rd;
  logic        WE3, issue_en;
  logic [31:0] WD3;
  logic [31:0] ALUop1, regOp2, a0;
  logic        stall;
  logic [5:0]  pending_cnt;

  int checks   = 0;
  int failures = 0;

  regfile_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DBG_ADDR(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .ad1(ad1), .ad2(ad2), .ad3(ad3),
    .WE3(WE3), .WD3(WD3),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .ALUop1(ALUop1), .regOp2(regOp2), .a0(a0),
    .stall(stall), .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE3 = 1'b0; ad3 = '0; WD3 = '0;
    issue_en = 1'b0; issue_rd = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    ad1 = '0; ad2 = '0;
    idle();

    // Reset state
    #3;
    chk("rst_aluop1", ALUop1, 32'h0);
    chk("rst_a0", a0, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_cnt", {26'h0, pending_cnt}, 32'h0);
    #9 rst_n = 1'b1;

    // x0 ignores writes and issues
    WE3 = 1'b1; ad3 = 5'd0; WD3 = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_rd = 5'd0;
    step(); idle(); ad1 = 5'd0; #1;
    chk("x0_read", ALUop1, 32'h0);
    chk("x0_cnt", {26'h0, pending_cnt}, 32'h0);
    chk("x0_stall", {31'h0, stall}, 32'h0);

    // Plain write/read
    WE3 = 1'b1; ad3 = 5'd5; WD3 = 32'h0000_DEAD;
    step(); idle(); ad1 = 5'd5; ad2 = 5'd0; #1;
    chk("wr_x5", ALUop1, 32'h0000_DEAD);

    // Debug port: visible after the write edge only
    WE3 = 1'b1; ad3 = 5'd10; WD3 = 32'hCAFE_F00D; #1;
    chk("a0_before_edge", a0, 32'h0);
    step(); idle(); #1;
    chk("a0_after_edge", a0, 32'hCAFE_F00D);

    // RAW hazard on x7
    issue_en = 1'b1; issue_rd = 5'd7;
    step(); idle(); ad1 = 5'd7; ad2 = 5'd0; #1;
    chk("haz_stall", {31'h0, stall}, 32'h1);
    chk("haz_cnt", {26'h0, pending_cnt}, 32'h1);
    ad1 = 5'd0; ad2 = 5'd7; #1;
    chk("haz_stall_port2", {31'h0, stall}, 32'h1);
    ad1 = 5'd7; ad2 = 5'd0;
    WE3 = 1'b1; ad3 = 5'd7; WD3 = 32'h0000_1234; #1;
`ifdef REGFILE_BYPASS_EN
    chk("haz_wb_stall", {31'h0, stall}, 32'h0);
    chk("haz_wb_fwd", ALUop1, 32'h0000_1234);
`else
    chk("haz_wb_stall", {31'h0, stall}, 32'h1);
    chk("haz_wb_old", ALUop1, 32'h0);
`endif
    step(); idle(); #1;
    chk("haz_after_stall", {31'h0, stall}, 32'h0);
    chk("haz_after_data", ALUop1, 32'h0000_1234);
    chk("haz_after_cnt", {26'h0, pending_cnt}, 32'h0);

    // Collision: issue wins, data still written
    issue_en = 1'b1; issue_rd = 5'd3;
    step(); idle(); #1;
    chk("col_pre_cnt", {26'h0, pending_cnt}, 32'h1);
    issue_en = 1'b1; issue_rd = 5'd3;
    WE3 = 1'b1; ad3 = 5'd3; WD3 = 32'h55;
    step(); idle(); ad1 = 5'd3; #1;
    chk("col_data", ALUop1, 32'h55);
    chk("col_busy", {31'h0, stall}, 32'h1);
    chk("col_cnt", {26'h0, pending_cnt}, 32'h1);
    WE3 = 1'b1; ad3 = 5'd3; WD3 = 32'h55;
    step(); idle(); #1;
    chk("col_clear_cnt", {26'h0, pending_cnt}, 32'h0);
    chk("col_clear_stall", {31'h0, stall}, 32'h0);

    // Count: fill all 31 registers
    for (int i = 1; i < 32; i++) begin
      issue_en = 1'b1; issue_rd = 5'(i);
      step();
    end
    idle(); #1;
    chk("cnt_full", {26'h0, pending_cnt}, 32'd31);
    WE3 = 1'b1; ad3 = 5'd4; WD3 = 32'h104;
    step(); idle(); #1;
    chk("cnt_wb4", {26'h0, pending_cnt}, 32'd30);
    // New set on x4 with clear of x9 in the same edge nets to zero
    issue_en = 1'b1; issue_rd = 5'd4;
    WE3 = 1'b1; ad3 = 5'd9; WD3 = 32'h109;
    step(); idle(); #1;
    chk("cnt_net0", {26'h0, pending_cnt}, 32'd30);
    // Re-issue to a busy register does not double count
    issue_en = 1'b1; issue_rd = 5'd5;
    step(); idle(); #1;
    chk("cnt_reissue", {26'h0, pending_cnt}, 32'd30);
    // Drain all (x9 is already clear: data-only write)
    for (int i = 1; i < 32; i++) begin
      WE3 = 1'b1; ad3 = 5'(i); WD3 = 32'h100 + 32'(i);
      step();
    end
    idle(); ad1 = 5'd20; ad2 = 5'd31; #1;
    chk("cnt_empty", {26'h0, pending_cnt}, 32'd0);
    chk("drain_x20", ALUop1, 32'h114);
    chk("drain_x31", regOp2, 32'h11F);
    chk("drain_a0", a0, 32'h10A);
    chk("drain_stall", {31'h0, stall}, 32'h0);

    // Mid-operation asynchronous reset
    issue_en = 1'b1; issue_rd = 5'd7;
    WE3 = 1'b1; ad3 = 5'd5; WD3 = 32'h0000_DEAD;
    step(); idle(); ad1 = 5'd5; ad2 = 5'd7; #1;
    chk("pre_rst_data", ALUop1, 32'h0000_DEAD);
    chk("pre_rst_stall", {31'h0, stall}, 32'h1);
    chk("pre_rst_cnt", {26'h0, pending_cnt}, 32'h1);
    rst_n = 1'b0; #1;
    chk("async_rst_data", ALUop1, 32'h0);
    chk("async_rst_cnt", {26'h0, pending_cnt}, 32'h0);
    chk("async_rst_stall", {31'h0, stall}, 32'h0);
    chk("async_rst_a0", a0, 32'h0);

    // Issue held across reset release acts on the first edge with rst_n high
    @(negedge clk);
    rst_n = 1'b1;
    issue_en = 1'b1; issue_rd = 5'd6;
    step(); idle(); ad1 = 5'd6; ad2 = 5'd0; #1;
    chk("post_rst_cnt", {26'h0, pending_cnt}, 32'h1);
    chk("post_rst_stall", {31'h0, stall}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 5, giving the register index width; depth is 2**ADDRESS_WIDTH.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the register data width.
REQ-003 The block SHALL have parameter DBG_ADDR, default 10, giving the register index mirrored on a0.
REQ-004 One clock and one reset: the block SHALL use clk and rst_n, with reset asynchronous and active-low.
REQ-005 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ad1  in  ADDRESS_WIDTH  read port 1 index
- ad2  in  ADDRESS_WIDTH  read port 2 index
- ad3  in  ADDRESS_WIDTH  write-back index
- WE3  in  1  write-back enable
- WD3  in  DATA_WIDTH  write-back data
- issue_en  in  1  instruction issued that will write issue_rd
- issue_rd  in  ADDRESS_WIDTH  destination of issued instruction
- ALUop1  out  DATA_WIDTH  read data, port 1
- regOp2  out  DATA_WIDTH  read data, port 2
- a0  out  DATA_WIDTH  contents of register DBG_ADDR
- stall  out  1  a read source is pending (scoreboard hazard)
- pending_cnt  out  ADDRESS_WIDTH+1  number of busy registers

Function
REQ-006 Writes SHALL be synchronous: at posedge clk, if WE3 and ad3!=0, reg[ad3] <= WD3.
REQ-007 Register 0 SHALL read as 0 always, and writes to it SHALL be ignored.
REQ-008 Reads SHALL be combinational: ALUop1=reg[ad1], regOp2=reg[ad2], a0=reg[DBG_ADDR], with zero-cycle latency.
REQ-009 The scoreboard SHALL hold one busy bit per register, with busy[0] hardwired 0.
REQ-010 At posedge clk, issue_en with issue_rd!=0 SHALL set busy[issue_rd].
REQ-011 At posedge clk, WE3 with ad3!=0 SHALL clear busy[ad3].
REQ-012 If issue and write-back target the same register in the same cycle, issue SHALL win: the busy bit ends at 1 and the data is still written.
REQ-013 Issuing to a register that is already busy SHALL leave it busy, with no double count.
REQ-014 A write-back to a register that is not busy SHALL update the data only; the scoreboard is unchanged.
REQ-015 stall SHALL be combinational, asserted when (busy[ad1] and not bypass1) or (busy[ad2] and not bypass2); index 0 never stalls.
REQ-016 pending_cnt SHALL be a registered count equal to the population of busy bits after each edge: +1 on a new set, -1 on a clear, net 0 when both happen on different registers.
REQ-017 pending_cnt SHALL saturate at neither bound; the maximum is 2**ADDRESS_WIDTH-1 and the minimum is 0 by construction.

Reset
REQ-018 While rst_n is 0, all registers, all busy bits and pending_cnt SHALL be 0 immediately, without waiting for a clk edge.
REQ-019 Consequently, during reset ALUop1, regOp2 and a0 SHALL be 0 and stall SHALL be 0.
REQ-020 An issue or write-back in the cycle in which reset deasserts SHALL take effect at the first posedge with rst_n high.
REQ-021 Reset asserted mid-operation SHALL discard all pending hazards.

Configuration
REQ-022 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
- Defined: bypassN is true when WE3, ad3!=0 and ad3==adN.
  - ALUop1/regOp2 SHALL then return WD3 in the same cycle.
  - That source SHALL NOT assert stall.
- Undefined: bypassN SHALL be constant 0.
  - Reads return the pre-write value.
  - stall stays asserted until the cycle after write-back.

Verification
REQ-023 Reset: drive rst_n=0 mid-run after writing x5=0xDEAD -> ALUop1(ad1=5)=0, pending_cnt=0, stall=0 asynchronously.
REQ-024 x0: WE3=1, ad3=0, WD3=0xFFFFFFFF, then ad1=0 -> ALUop1=0; issue_rd=0 -> pending_cnt stays 0.
REQ-025 Hazard: issue_rd=7; next cycle ad1=7 -> stall=1, pending_cnt=1.
- With WE3=1, ad3=7, WD3=0x1234: BYPASS_EN defined -> stall=0 and ALUop1=0x1234 in that cycle.
- Undefined -> stall=1 in that cycle, then stall=0 and ALUop1=0x1234 the next cycle.
REQ-026 Collision: busy[3]=1, same cycle issue_rd=3 and WE3 ad3=3 WD3=0x55 -> reg[3]=0x55, busy[3]=1, pending_cnt unchanged.
REQ-027 Count: issue x1..x31 on consecutive cycles -> pending_cnt=31; write back all 31 -> pending_cnt=0.
- Simultaneous issue x4 with write-back x9 -> count unchanged.
REQ-028 Debug port: write x10=0xCAFEF00D -> a0=0xCAFEF00D the cycle after the write edge.
